// File: rtl/pong_game_ctrl.sv
// Game-flow sequencer for pong: serve/play/point/pause/game-over control,
// miss detection at the screen edges, score keeping and winner flag.
module pong_game_ctrl #(
  parameter int X_MAX        = 639,
  parameter int EDGE         = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       btn_start,
  input  logic [9:0] ball_x_l,
  input  logic [9:0] ball_x_r,
  output logic       ball_en,
  output logic       ball_serve,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    POINT     = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  localparam logic [9:0] EDGE_X     = 10'(EDGE);
  localparam logic [9:0] X_LIM      = 10'(X_MAX);
  localparam logic [9:0] R_EDGE     = 10'(X_MAX - EDGE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] score1_d, score2_d;
  logic       dir_d, winner_d, serve_d;

  logic sync_1, sync_2, sync_prev, start_pulse;
  logic miss_left, miss_right;

  // The extra registered stage gives a clean one-cycle start_pulse.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1      <= 1'b0;
      sync_2      <= 1'b0;
      sync_prev   <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      sync_1      <= btn_start;
      sync_2      <= sync_1;
      sync_prev   <= sync_2;
      start_pulse <= sync_2 & ~sync_prev;
    end
  end

  // A left edge above X_MAX means the ball wrapped below zero.
  assign miss_left  = (ball_x_l <= EDGE_X) || (ball_x_l > X_LIM);
  assign miss_right = !miss_left && (ball_x_r >= R_EDGE) && (ball_x_l <= X_LIM);

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    score1_d = score1;
    score2_d = score2;
    dir_d    = serve_dir;
    winner_d = winner;
    serve_d  = 1'b0;
    case (state_q)
      IDLE, GAME_OVER: begin
        if (start_pulse) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          dir_d    = 1'b0;
          winner_d = 1'b0;
          timer_d  = 8'd0;
          serve_d  = 1'b1;
          state_d  = SERVE;
        end
      end
      SERVE, POINT: begin
        if (refresh_tick) begin
          if (timer_q == ((state_q == SERVE) ? SERVE_LAST : POINT_LAST)) begin
            timer_d = 8'd0;
            serve_d = (state_q == POINT);
            state_d = (state_q == SERVE) ? PLAY : SERVE;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
      PLAY: begin
        if (miss_left) begin
          score1_d = score1 + 4'd1;
          timer_d  = 8'd0;
          if (score1_d == WIN) begin
            winner_d = 1'b0;
            state_d  = GAME_OVER;
          end else begin
            dir_d   = 1'b0;
            state_d = POINT;
          end
        end else if (miss_right) begin
          score2_d = score2 + 4'd1;
          timer_d  = 8'd0;
          if (score2_d == WIN) begin
            winner_d = 1'b1;
            state_d  = GAME_OVER;
          end else begin
            dir_d   = 1'b1;
            state_d = POINT;
          end
        end else if (start_pulse) begin
          timer_d = 8'd0;
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (start_pulse) begin
          timer_d = 8'd0;
          state_d = PLAY;
        end
      end
      default: begin
        timer_d = 8'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values so they align with state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= 8'd0;
      score1     <= 4'd0;
      score2     <= 4'd0;
      serve_dir  <= 1'b0;
      winner     <= 1'b0;
      ball_serve <= 1'b0;
      ball_en    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      score1     <= score1_d;
      score2     <= score2_d;
      serve_dir  <= dir_d;
      winner     <= winner_d;
      ball_serve <= serve_d;
      ball_en    <= (state_d == PLAY);
      game_over  <= (state_d == GAME_OVER);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: a game-rule model compared every
// cycle, plus directed checks with hand-computed values.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       refresh_tick;
  logic       btn_start;
  logic [9:0] ball_x_l;
  logic [9:0] ball_x_r;
  logic       ball_en, ball_serve, serve_dir, game_over, winner;
  logic [3:0] score1, score2;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  pong_game_ctrl dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .btn_start(btn_start),
    .ball_x_l(ball_x_l), .ball_x_r(ball_x_r), .ball_en(ball_en),
    .ball_serve(ball_serve), .serve_dir(serve_dir), .score1(score1),
    .score2(score2), .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Game model: mode numbers follow the published state codes.
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_PAUSE = 3, M_POINT = 4, M_OVER = 5;
  int m_mode, m_ticks, m_s1, m_s2;
  bit m_dir, m_win, m_serve;
  bit btn_hist [4];  // button level seen at the last four clock edges

  always @(posedge clk or negedge reset) begin
    bit press, left, right;
    if (!reset) begin
      m_mode = M_IDLE; m_ticks = 0; m_s1 = 0; m_s2 = 0;
      m_dir = 0; m_win = 0; m_serve = 0;
      for (int i = 0; i < 4; i++) btn_hist[i] = 0;
    end else begin
      // A press acts three edges after it is first seen at an edge.
      press = btn_hist[2] && !btn_hist[3];
      for (int i = 3; i > 0; i--) btn_hist[i] = btn_hist[i-1];
      btn_hist[0] = btn_start;
      left  = (int'(ball_x_l) <= 2) || (int'(ball_x_l) > 639);
      right = !left && (int'(ball_x_r) >= 637) && (int'(ball_x_l) <= 639);
      m_serve = 0;
      if (m_mode == M_IDLE || m_mode == M_OVER) begin
        if (press) begin
          m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0;
          m_serve = 1; m_ticks = 0; m_mode = M_SERVE;
        end
      end else if (m_mode == M_SERVE) begin
        if (refresh_tick) m_ticks++;
        if (m_ticks == 60) begin m_ticks = 0; m_mode = M_PLAY; end
      end else if (m_mode == M_POINT) begin
        if (refresh_tick) m_ticks++;
        if (m_ticks == 90) begin m_ticks = 0; m_serve = 1; m_mode = M_SERVE; end
      end else if (m_mode == M_PLAY) begin
        if (left) begin
          m_s1++;
          if (m_s1 == 7) begin m_win = 0; m_mode = M_OVER; end
          else begin m_dir = 0; m_ticks = 0; m_mode = M_POINT; end
        end else if (right) begin
          m_s2++;
          if (m_s2 == 7) begin m_win = 1; m_mode = M_OVER; end
          else begin m_dir = 1; m_ticks = 0; m_mode = M_POINT; end
        end else if (press) begin
          m_mode = M_PAUSE;
        end
      end else if (m_mode == M_PAUSE) begin
        if (press) m_mode = M_PLAY;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_state",      32'(state),      32'(m_mode));
    check("cyc_ball_en",    32'(ball_en),    32'(m_mode == M_PLAY));
    check("cyc_game_over",  32'(game_over),  32'(m_mode == M_OVER));
    check("cyc_ball_serve", 32'(ball_serve), 32'(m_serve));
    check("cyc_serve_dir",  32'(serve_dir),  32'(m_dir));
    check("cyc_score1",     32'(score1),     32'(m_s1));
    check("cyc_score2",     32'(score2),     32'(m_s2));
    check("cyc_winner",     32'(winner),     32'(m_win));
  end

  task automatic tick();
    refresh_tick = 1'b1;
    @(negedge clk);
    refresh_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      tick();
    end
  endtask

  task automatic press();
    btn_start = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic release_btn();
    btn_start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic centre_ball();
    ball_x_l = 10'd300;
    ball_x_r = 10'd310;
  endtask

  task automatic right_point();
    ball_x_l = 10'd629; ball_x_r = 10'd638;
    @(negedge clk);
    centre_ball();
    ticks(90);
    @(negedge clk);
    ticks(60);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; refresh_tick = 1'b0; btn_start = 1'b0;
    centre_ball();
    repeat (2) @(negedge clk);
    check("reset_outputs", {ball_en, ball_serve, serve_dir, score1, score2, game_over, winner, state}, 0);
    reset = 1'b1;
    @(negedge clk);

    // Start: no response for three edges, SERVE with a serve pulse on the fourth.
    btn_start = 1'b1;
    repeat (3) @(negedge clk);
    check("start_latency_idle", 32'(state), 0);
    @(negedge clk);
    check("start_serve_state", 32'(state), 1);
    check("start_serve_pulse", 32'(ball_serve), 1);
    check("start_ball_en", 32'(ball_en), 0);
    @(negedge clk);
    check("serve_pulse_width", 32'(ball_serve), 0);
    btn_start = 1'b0;

    ticks(59);
    check("serve_after_59", 32'(state), 1);
    @(negedge clk);
    tick();
    check("play_after_60", 32'(state), 2);
    check("play_ball_en", 32'(ball_en), 1);

    // Left miss held for five cycles scores once.
    ball_x_l = 10'd1;
    repeat (5) @(negedge clk);
    check("left_miss_score1", 32'(score1), 1);
    check("left_miss_state", 32'(state), 4);
    check("left_miss_dir", 32'(serve_dir), 0);
    centre_ball();
    ticks(89);
    check("point_after_89", 32'(state), 4);
    @(negedge clk);
    tick();
    check("point_reserve_state", 32'(state), 1);
    check("point_reserve_pulse", 32'(ball_serve), 1);
    @(negedge clk);
    ticks(60);
    @(negedge clk);

    // Wrapped left edge plus a right-edge position counts as a left miss.
    ball_x_l = 10'd1020; ball_x_r = 10'd637;
    @(negedge clk);
    check("wrap_score1", 32'(score1), 2);
    check("wrap_score2", 32'(score2), 0);
    centre_ball();
    ticks(90);
    @(negedge clk);
    ticks(60);
    @(negedge clk);

    // Pause and resume; a miss position is ignored while paused.
    press();
    check("pause_state", 32'(state), 3);
    check("pause_ball_en", 32'(ball_en), 0);
    release_btn();
    ball_x_l = 10'd1;
    @(negedge clk);
    check("pause_no_score", 32'(score1), 2);
    centre_ball();
    press();
    check("resume_state", 32'(state), 2);
    release_btn();

    repeat (6) right_point();
    check("right_score2_6", 32'(score2), 6);
    check("right_dir", 32'(serve_dir), 1);
    ball_x_l = 10'd629; ball_x_r = 10'd638;
    @(negedge clk);
    check("win_score2", 32'(score2), 7);
    check("win_state", 32'(state), 5);
    check("win_winner", 32'(winner), 1);
    check("win_game_over", 32'(game_over), 1);
    check("win_score1_held", 32'(score1), 2);
    centre_ball();

    press();
    check("restart_state", 32'(state), 1);
    check("restart_pulse", 32'(ball_serve), 1);
    check("restart_scores", {score1, score2}, 0);
    check("restart_winner", 32'(winner), 0);
    release_btn();
    ticks(60);
    @(negedge clk);

    // Score once, pause, then assert reset between clock edges.
    ball_x_l = 10'd2;
    @(negedge clk);
    centre_ball();
    ticks(90);
    @(negedge clk);
    ticks(60);
    @(negedge clk);
    press();
    release_btn();
    check("pre_reset_score1", 32'(score1), 1);
    #2 reset = 1'b0;
    #1 check("async_reset_pause", {ball_en, ball_serve, serve_dir, score1, score2, game_over, winner, state}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    press();
    release_btn();
    ticks(60);
    @(negedge clk);
    check("replay_ball_en", 32'(ball_en), 1);
    #2 reset = 1'b0;
    #1 check("async_reset_ball_en", 32'(ball_en), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-flow sequencer for the ball datapath.
- Freezes and releases the ball, commands a re-serve from screen centre with a chosen direction, and detects misses at the left and right screen edges.
- Keeps both players' scores and declares the winner.
- Sits between the start button (already debounced), the VGA frame tick, and the ball/score-display blocks.

Parameters:
- X_MAX, 639, right border of display area (pixels).
- EDGE, 2, miss margin in pixels from the left/right border.
- SERVE_FRAMES, 60, frames ball is held before a serve launches (1..255).
- POINT_FRAMES, 90, frames of pause after a point (1..255).
- WIN_SCORE, 7, points needed to win (1..15).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- refresh_tick  in  1  one-cycle pulse per frame, from the VGA timing block.
- btn_start  in  1  start/pause button level, debounced, asynchronous to clk.
- ball_x_l  in  10  ball left edge.
- ball_x_r  in  10  ball right edge.
- ball_en  out  1  1 = ball may move; 0 = ball frozen.
- ball_serve  out  1  one-cycle pulse; ball reloads centre position and takes serve_dir.
- serve_dir  out  1  1 = serve toward +x (right), 0 = toward -x (left).
- score1  out  4  right-side player score.
- score2  out  4  left-side player score.
- game_over  out  1  high while in GAME_OVER.
- winner  out  1  0 = player 1 won, 1 = player 2; valid while game_over.
- state  out  3  current FSM state, for debug/overlay.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, timer=0, all outputs 0, both sync flops 0.
- Start input: 2-flop synchronizer, then rising-edge detect gives start_pulse. Latency from btn_start rise to start_pulse is 3 clk. Holding the button yields exactly one pulse.
- Miss detect, combinational:
  - miss_left = (ball_x_l <= EDGE) || (ball_x_l > X_MAX). The second term covers wrap below 0.
  - miss_right = (ball_x_r >= X_MAX-EDGE) && (ball_x_l <= X_MAX).
  - Both true: miss_left wins.
- All outputs are registered. ball_en is a function of the registered state: 1 only in PLAY.
- States and encodings: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, GAME_OVER=5.
- IDLE:
  - On start_pulse: clear scores, serve_dir=0, timer=0, ball_serve=1 for the next cycle, go to SERVE.
- SERVE:
  - Increment timer on each refresh_tick.
  - On a refresh_tick with timer==SERVE_FRAMES-1: timer=0, go to PLAY.
  - start_pulse is ignored.
- PLAY:
  - Check every cycle, in priority order: miss_left, then miss_right, then start_pulse.
  - miss_left: score1+1. If the new score1==WIN_SCORE, go to GAME_OVER with winner=0. Otherwise serve_dir=0 (serve toward the conceding left player) and go to POINT.
  - miss_right: score2+1. If the new score2==WIN_SCORE, go to GAME_OVER with winner=1. Otherwise serve_dir=1 and go to POINT.
  - start_pulse with no miss: go to PAUSE.
  - Only one point is scored per rally, because the state leaves PLAY on the next edge.
- PAUSE:
  - ball_en=0. Timer and scores hold.
  - On start_pulse: return to PLAY.
- POINT:
  - Count refresh_ticks as in SERVE, up to POINT_FRAMES-1.
  - Then: timer=0, ball_serve=1 for the next cycle, go to SERVE.
- GAME_OVER:
  - game_over=1. Scores and winner hold.
  - On start_pulse: clear scores and winner, serve_dir=0, ball_serve pulse, go to SERVE.
- Counters:
  - Scores are 4-bit and never exceed WIN_SCORE.
  - Timer is 8-bit and is reset on every state entry.
- Concurrent refresh_tick and a state transition: the transition takes effect and the tick is not counted in the new state.
- Reset asserted mid-game: immediate return to IDLE with all outputs 0. ball_en drops in the same cycle reset asserts.
- ball_serve pulse: exactly one cycle wide. It is aligned with the first cycle that state reads SERVE.

Test Plan:
- Reset release, btn_start rises at t0 → start_pulse at t0+3. State goes to SERVE with one ball_serve pulse; serve_dir=0, scores 0/0, ball_en=0.
- In SERVE, apply 60 refresh_ticks with defaults → state becomes PLAY on the cycle after the 60th tick and ball_en=1. After 59 ticks, state is still SERVE.
- In PLAY, set ball_x_l=1 → score1 goes 0→1, serve_dir=0, state goes to POINT. After 90 ticks, ball_serve pulses and state is SERVE. Holding miss_left for 5 cycles scores only 1.
- In PLAY, apply ball_x_l=1020 (wrapped) together with ball_x_r=637 → counted as a left miss: score1 increments and score2 is unchanged.
- With score2=6, apply ball_x_r=638, ball_x_l=629 → score2=7, state GAME_OVER, winner=1, game_over=1. Then start_pulse → scores 0/0, SERVE, one ball_serve pulse.
- In PLAY, start_pulse → PAUSE with ball_en=0 and scores unchanged; second start_pulse → PLAY. Drive reset low mid-PAUSE → all outputs 0 and state IDLE, with no clock edge required.
